div: RTL
========

Name: div

Overview:
- Multi-cycle radix-2 restoring divider serving DIV/DIVU in the execute stage.
- Downstream of the execute stage: takes start, operands and sign mode; returns a 64-bit {remainder, quotient} and a ready flag.
- Execute stage holds start high and stalls the pipeline until ready is seen, then writes the result to HI/LO.
- Adds an annul input so a flushed or cancelled division aborts cleanly.

Parameters:
- DATA_W, 32, operand width; iteration count equals DATA_W; result width 2*DATA_W.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU)
- opdata1_i  in  DATA_W  dividend
- opdata2_i  in  DATA_W  divisor
- start_i  in  1  request; held high by execute stage until ready_o seen
- annul_i  in  1  cancel in-flight operation (pipeline flush)
- result_o  out  2*DATA_W  {remainder[63:32], quotient[31:0]}; HI = remainder, LO = quotient
- ready_o  out  1  result_o valid

Behaviour:
- Reset: rst high at an edge sets state=FREE, cnt=0, ready_o=0, result_o=0. Reset mid-operation aborts with no result.
- Outputs are registered. result_o is 0 whenever ready_o=0.
- States: FREE, BYZERO, ON, END.
- FREE:
  - start_i=1 & annul_i=0 & divisor==0 -> BYZERO.
  - start_i=1 & annul_i=0 & divisor!=0 -> ON.
  - On entering ON: latch |dividend| and |divisor| (two's-complement magnitude when signed_div_i=1 and MSB set), latch sign flags, cnt=0, 65-bit work register = {0, |dividend|, 1'b0}.
  - Otherwise stay in FREE.
- BYZERO: next edge -> END with result_o=0. Divide-by-zero result is defined as 0/0.
- ON, each cycle:
  - trial = work[64:32] - {0, |divisor|}.
  - If trial is negative: work <<= 1 (quotient bit 0).
  - Else: work = {trial[31:0], work[31:0], 1'b1}.
  - cnt++.
- ON completion:
  - When cnt reaches DATA_W, final values are raw quotient = work[31:0] and raw remainder = work[64:33].
  - Sign correction: quotient negated if signed and dividend sign != divisor sign; remainder negated if signed and dividend negative.
  - Go to END with ready_o=1 and result_o = corrected value.
- Latency: start sampled at edge 0 -> ready_o=1 after edge 33 (32 iterations plus the finishing edge). Divide-by-zero: ready_o=1 after edge 2.
- END:
  - Hold ready_o=1 and result_o stable while start_i=1.
  - start_i=0 sampled -> FREE, ready_o=0, result_o=0 at that edge.
- annul_i:
  - annul_i=1 in ON or BYZERO -> FREE next edge, ready_o stays 0.
  - annul_i=1 in FREE blocks acceptance.
  - annul_i is ignored in END.
- Operand changes after acceptance are ignored; latched values are used.
- Overflow case 0x80000000 / 0xFFFFFFFF signed -> quotient 0x80000000, remainder 0. No trap.
- start_i dropped during ON: the operation completes and END is entered. With start_i already 0, END falls to FREE on the next edge. ready_o is high for exactly one cycle.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in FREE, on accept with divisor!=0 and |dividend| < |divisor| (unsigned magnitude compare), skip ON and go directly to END.
  - quotient = 0; remainder = dividend unmodified (original sign preserved).
  - ready_o=1 after edge 1.
- Undefined: every nonzero-divisor operation takes the full 32-iteration path with identical results.

Test Plan:
- DIVU 100 / 7, start held -> ready_o high at edge 33; result_o = {0x00000002, 0x0000000E}; drop start -> ready_o=0 and result_o=0 next edge.
- DIV -7 (0xFFFFFFF9) / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 7 / -2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}. DIVU 0xFFFFFFFF / 1 -> {0, 0xFFFFFFFF}.
- Divisor 0, start high -> ready_o=1 after edge 2, result_o=0. Then start low -> FREE; a new DIVU 9/3 -> {0, 3}.
- Start DIVU 1000/10, assert annul_i at iteration 10 -> FREE next edge, ready_o never rises. Separately, rst high at iteration 20 -> all outputs 0 next edge.
- DIV_EARLY_OUT_EN: DIVU 5/9 -> ready_o after edge 1, {0x00000005, 0}. Without the macro, same result at edge 33.

Source files
------------

// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU with annul support.
// Optional DIV_EARLY_OUT_EN: finish immediately when |dividend| < |divisor|.
module div #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [2*DATA_W:0]   work_reg, work_next;
  logic [DATA_W-1:0]   dvs_mag_reg, dvs_mag_next;
  logic                dvd_neg_reg, dvd_neg_next;
  logic                dvs_neg_reg, dvs_neg_next;
  logic                ready_reg, ready_next;
  logic [2*DATA_W-1:0] result_reg, result_next;

  logic                dvd_neg, dvs_neg;
  logic [DATA_W-1:0]   dvd_mag, dvs_mag;
  logic [DATA_W:0]     trial;
  logic [DATA_W-1:0]   q_raw, r_raw, q_fix, r_fix;

  always_comb begin
    dvd_neg = signed_div_i & opdata1_i[DATA_W-1];
    dvs_neg = signed_div_i & opdata2_i[DATA_W-1];
    dvd_mag = dvd_neg ? (~opdata1_i + 1'b1) : opdata1_i;
    dvs_mag = dvs_neg ? (~opdata2_i + 1'b1) : opdata2_i;
    // Trial subtraction of the divisor from the upper partial remainder.
    trial   = work_reg[2*DATA_W:DATA_W] - {1'b0, dvs_mag_reg};
    q_raw   = work_reg[DATA_W-1:0];
    r_raw   = work_reg[2*DATA_W:DATA_W+1];
    q_fix   = (dvd_neg_reg ^ dvs_neg_reg) ? (~q_raw + 1'b1) : q_raw;
    r_fix   = dvd_neg_reg ? (~r_raw + 1'b1) : r_raw;
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    work_next    = work_reg;
    dvs_mag_next = dvs_mag_reg;
    dvd_neg_next = dvd_neg_reg;
    dvs_neg_next = dvs_neg_reg;
    ready_next   = ready_reg;
    result_next  = result_reg;
    case (state_reg)
      FREE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_next = BYZERO;
          end else begin
`ifdef DIV_EARLY_OUT_EN
            if (dvd_mag < dvs_mag) begin
              state_next  = END;
              ready_next  = 1'b1;
              result_next = {opdata1_i, {DATA_W{1'b0}}};
            end else
`endif
            begin
              state_next   = ON;
              cnt_next     = '0;
              work_next    = {1'b0, dvd_mag, 1'b0};
              dvs_mag_next = dvs_mag;
              dvd_neg_next = dvd_neg;
              dvs_neg_next = dvs_neg;
            end
          end
        end
      end
      BYZERO: begin
        // Result stays 0; ready rises one edge after reaching END.
        state_next = annul_i ? FREE : END;
      end
      ON: begin
        if (annul_i) begin
          state_next = FREE;
        end else if (cnt_reg == CNT_W'(DATA_W)) begin
          state_next  = END;
          ready_next  = 1'b1;
          result_next = {r_fix, q_fix};
        end else begin
          if (trial[DATA_W])
            work_next = {work_reg[2*DATA_W-1:0], 1'b0};
          else
            work_next = {trial[DATA_W-1:0], work_reg[DATA_W-1:0], 1'b1};
          cnt_next = cnt_reg + 1'b1;
        end
      end
      END: begin
        // ready is guaranteed to be seen for at least one cycle before release.
        if (!start_i && ready_reg) begin
          state_next  = FREE;
          ready_next  = 1'b0;
          result_next = '0;
        end else begin
          ready_next = 1'b1;
        end
      end
      default: state_next = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= FREE;
      cnt_reg     <= '0;
      work_reg    <= '0;
      dvs_mag_reg <= '0;
      dvd_neg_reg <= 1'b0;
      dvs_neg_reg <= 1'b0;
      ready_reg   <= 1'b0;
      result_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      work_reg    <= work_next;
      dvs_mag_reg <= dvs_mag_next;
      dvd_neg_reg <= dvd_neg_next;
      dvs_neg_reg <= dvs_neg_next;
      ready_reg   <= ready_next;
      result_reg  <= result_next;
    end
  end

  assign ready_o  = ready_reg;
  assign result_o = result_reg;

endmodule
